// File: rtl/arbitro_somador.sv
// Round-robin sequencer sharing one external combinational adder between two clients.
// Captures the winner's operands, registers the sum/flags, adds signed overflow, pulses done.
module arbitro_somador #(
   parameter int NBITS = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0,
   input  logic [NBITS-1:0] a0,
   input  logic [NBITS-1:0] b0,
   input  logic             req1,
   input  logic [NBITS-1:0] a1,
   input  logic [NBITS-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [NBITS-1:0] S,
   output logic             N,
   output logic             Z,
   output logic             P,
   output logic             V,
   output logic             owner,
   output logic [NBITS-1:0] add_a,
   output logic [NBITS-1:0] add_b,
   input  logic [NBITS-1:0] add_s,
   input  logic             add_n,
   input  logic             add_z,
   input  logic             add_p
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_last_grant;
   logic             r_sel;
   logic [NBITS-1:0] r_op_a;
   logic [NBITS-1:0] r_op_b;
   logic             r_gnt0;
   logic             r_gnt1;
   logic             r_done0;
   logic             r_done1;
   logic [NBITS-1:0] r_s;
   logic             r_n;
   logic             r_z;
   logic             r_p;
   logic             r_v;
   logic             r_owner;

   logic             w_any_req;
   logic             w_sel_next;
   logic             w_v;

   // Contention goes to whichever client was not served last.
   always_comb begin
      w_any_req  = req0 | req1;
      w_sel_next = 1'b0;
      if (req0 && !req1) begin
         w_sel_next = 1'b0;
      end else if (req1 && !req0) begin
         w_sel_next = 1'b1;
      end else if (req0 && req1) begin
         w_sel_next = ~r_last_grant;
      end
   end

   // Overflow: operands agree in sign but the wrapped sum does not.
   assign w_v = (r_op_a[NBITS-1] == r_op_b[NBITS-1]) &&
                (add_s[NBITS-1] != r_op_a[NBITS-1]);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_sel        <= 1'b0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_gnt0       <= 1'b0;
         r_gnt1       <= 1'b0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_s          <= '0;
         r_n          <= 1'b0;
         r_z          <= 1'b0;
         r_p          <= 1'b0;
         r_v          <= 1'b0;
         r_owner      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done0 <= 1'b0;
               r_done1 <= 1'b0;
               if (w_any_req) begin
                  r_op_a  <= w_sel_next ? a1 : a0;
                  r_op_b  <= w_sel_next ? b1 : b0;
                  r_gnt0  <= ~w_sel_next;
                  r_gnt1  <= w_sel_next;
                  r_sel   <= w_sel_next;
                  r_state <= ST_CALC;
               end
            end
            ST_CALC: begin
               r_s          <= add_s;
               r_n          <= add_n;
               r_z          <= add_z;
               r_p          <= add_p;
               r_v          <= w_v;
               r_owner      <= r_sel;
               r_done0      <= ~r_sel;
               r_done1      <= r_sel;
               r_last_grant <= r_sel;
               r_gnt0       <= 1'b0;
               r_gnt1       <= 1'b0;
               r_state      <= ST_DONE;
            end
            ST_DONE: begin
               r_done0 <= 1'b0;
               r_done1 <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_gnt0  <= 1'b0;
               r_gnt1  <= 1'b0;
               r_done0 <= 1'b0;
               r_done1 <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign add_a = r_op_a;
   assign add_b = r_op_b;
   assign gnt0  = r_gnt0;
   assign gnt1  = r_gnt1;
   assign done0 = r_done0;
   assign done1 = r_done1;
   assign S     = r_s;
   assign N     = r_n;
   assign Z     = r_z;
   assign P     = r_p;
   assign V     = r_v;
   assign owner = r_owner;

endmodule

// File: doc/arbitro_somador.md
Name: arbitro_somador

Overview:
- Round-robin arbiter/sequencer that shares one combinational NBITS-bit two's-complement adder between two requesters. The adder produces sum S and flags N/Z/P.
- Latches the winning requester's operands, drives them to the shared adder, and registers the sum and flags. Adds an overflow flag V and returns a done pulse to the owner.
- Sits between two client datapaths and the single adder instance.

Parameters:
- NBITS, 8, operand/result width, two's complement.

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  request from client 0, level.
- a0  input  NBITS  client 0 operand A, signed.
- b0  input  NBITS  client 0 operand B, signed.
- req1  input  1  request from client 1, level.
- a1  input  NBITS  client 1 operand A, signed.
- b1  input  NBITS  client 1 operand B, signed.
- gnt0  output  1  one-cycle grant to client 0, operands captured.
- gnt1  output  1  one-cycle grant to client 1.
- done0  output  1  one-cycle pulse, result for client 0 valid.
- done1  output  1  one-cycle pulse, result for client 1 valid.
- S  output  NBITS  registered sum, signed.
- N  output  1  registered negative flag.
- Z  output  1  registered zero flag.
- P  output  1  registered even (parity) flag.
- V  output  1  registered signed-overflow flag.
- owner  output  1  index of the client that owns S/flags.
- add_a  output  NBITS  operand A to shared adder.
- add_b  output  NBITS  operand B to shared adder.
- add_s  input  NBITS  sum from shared adder.
- add_n  input  1  N flag from shared adder.
- add_z  input  1  Z flag from shared adder.
- add_p  input  1  P flag from shared adder.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - state=IDLE, last_grant=1 (client 0 has priority first).
  - op_a=op_b=0.
  - gnt0/1, done0/1, S, N, Z, P, V, owner all 0.
- add_a/add_b are driven directly from the op_a/op_b registers. The adder is combinational, so its result is usable in the same cycle.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - No req: stay; all pulses 0.
  - Exactly one req: select that client.
  - Both req: select client != last_grant.
  - On selection at edge t: op_a/op_b <= selected a/b, gnt_sel <= 1 (high during cycle t+1 only), sel register updated, state <= CALC.
- CALC (cycle t+1):
  - At edge: S <= add_s, N <= add_n, Z <= add_z, P <= add_p, owner <= sel.
  - V <= (op_a[NBITS-1]==op_b[NBITS-1]) && (add_s[NBITS-1]!=op_a[NBITS-1]).
  - done_sel <= 1, last_grant <= sel, gnt <= 0, state <= DONE.
- DONE (cycle t+2): done_sel high this cycle only; at edge done <= 0, state <= IDLE.
- Latency and throughput:
  - req sampled at edge t -> gnt cycle t+1 -> done/result valid cycle t+2.
  - One operation per 3 cycles.
- Request rules:
  - Request is level-sensitive; requests are ignored in CALC/DONE.
  - Client must drop req in the cycle it sees its gnt. A req still high when IDLE is re-entered is a new request.
  - A held-high req from both clients alternates 0,1,0,1...
- Operands are captured at grant. Changes to a/b after gnt do not affect the result.
- S/flags/owner hold their values until the next CALC capture. They are not cleared by done falling.
- Flag arithmetic:
  - Sum wraps modulo 2^NBITS.
  - V is the only flag computed locally; N/Z/P are taken unmodified from the adder.
- gnt0&gnt1 and done0&done1 are never simultaneously high.
- Reset mid-operation (CALC or DONE):
  - Operation aborted; no done pulse.
  - Outputs return to reset values; priority returns to client 0.

Test Plan:
1. Assert reset 2 cycles with req0=req1=1 -> all outputs 0, no gnt; release reset -> gnt0 on the next cycle.
2. req0=1, a0=5, b0=-3 -> gnt0 at t+1, done0 at t+2, S=2, N=0, Z=0, P=1, V=0, owner=0; add_a=5, add_b=-3 during CALC.
3. req0 (a0=10, b0=20) and req1 (a1=-1, b1=-1) both held from same edge -> gnt0 first, done0 with S=30, P=1. Then gnt1 3 cycles after gnt0, done1 with S=0xFE, N=1, P=1, owner=1. Next alternation grants 0.
4. req1, a1=100, b1=100 -> S=0xC8 (-56), N=1, P=1, Z=0, V=1; then a1=-128, b1=-1 -> S=127, N=0, P=0, V=1.
5. req0, a0=-7, b0=7 -> S=0, Z=1, P=1, N=0, V=0; change a0 to 50 during gnt cycle -> result still 0.
6. Grant client 1, assert reset during CALC -> no done1, S=0, flags 0; after reset, both req -> client 0 granted first.
